// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit core.
// Fetches 16-bit instructions as two bytes and steers write-back, memory and PC.
module fetch_sequencer #(
  parameter int ADDR_W = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [3:0]        opcode,
  input  logic [15:0]       ctrl_flags,
  output logic [15:0]       instr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  input  logic [7:0]        alu_result,
  input  logic [7:0]        rs_data,
  input  logic [7:0]        rd_data,
  input  logic              branch_taken,
  output logic              reg_we,
  output logic [1:0]        reg_wsel,
  output logic [7:0]        load_data,
  output logic [ADDR_W-1:0] pc,
  output logic              retire,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH_HI,
    S_FETCH_LO,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [15:0]         r_instr;
  logic [7:0]          r_load;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_wdata;
  logic                r_reg_we;
  logic [1:0]          r_wsel;
  logic                r_retire;
  logic                r_halted;
  logic                r_jr;
  logic                r_br;
  logic                r_cond;
  logic                r_halt;
  logic                r_mem;
  logic                r_mw;

  logic                w_ack;
  logic [ADDR_W+7:0]   w_sext;
  logic [ADDR_W+7:0]   w_rs_ext;
  logic [ADDR_W+7:0]   w_alu_ext;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [ADDR_W-1:0]   w_pc_rel;
  logic                w_go;
  logic                w_d_halt;
  logic                w_d_mem;
  logic                w_d_alu;
  logic                w_unused;

  assign w_ack     = r_req & mem_ack;
  assign w_sext    = {{ADDR_W{r_instr[7]}}, r_instr[7:0]};
  assign w_rs_ext  = {{ADDR_W{1'b0}}, rs_data};
  assign w_alu_ext = {{ADDR_W{1'b0}}, alu_result};
  assign w_pc_inc  = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_pc_rel  = r_pc + w_sext[ADDR_W-1:0];
  assign w_go      = (r_jr | r_br) & (~r_cond | branch_taken);
  assign w_d_halt  = ctrl_flags[9];
  assign w_d_mem   = ctrl_flags[1] | ctrl_flags[2];
  assign w_d_alu   = ~|{ctrl_flags[9], ctrl_flags[5:0]};
  assign w_unused  = ^{ctrl_flags[15:10], ctrl_flags[8], ctrl_flags[6]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_FETCH_HI;
      r_pc     <= RESET_PC;
      r_instr  <= '0;
      r_load   <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_reg_we <= 1'b0;
      r_wsel   <= 2'd0;
      r_retire <= 1'b0;
      r_halted <= 1'b0;
      r_jr     <= 1'b0;
      r_br     <= 1'b0;
      r_cond   <= 1'b0;
      r_halt   <= 1'b0;
      r_mem    <= 1'b0;
      r_mw     <= 1'b0;
    end else begin
      r_reg_we <= 1'b0;
      r_retire <= 1'b0;
      unique case (r_state)
        S_FETCH_HI: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= r_pc;
          end else if (w_ack) begin
            r_req         <= 1'b0;
            r_instr[15:8] <= mem_rdata;
            r_pc          <= w_pc_inc;
            r_state       <= S_FETCH_LO;
          end
        end
        S_FETCH_LO: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= r_pc;
          end else if (w_ack) begin
            r_req        <= 1'b0;
            r_instr[7:0] <= mem_rdata;
            r_pc         <= w_pc_inc;
            r_state      <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_jr   <= ctrl_flags[4];
          r_br   <= ctrl_flags[5];
          r_cond <= ctrl_flags[7];
          r_halt <= w_d_halt;
          r_mem  <= w_d_mem;
          r_mw   <= ctrl_flags[2];
          // Single-cycle EXEC: strobes are armed here so they coincide with EXEC
          if (!w_d_halt && !w_d_mem) begin
            r_retire <= 1'b1;
            if (ctrl_flags[3]) begin
              r_reg_we <= 1'b1;
              r_wsel   <= 2'd3;
            end else if (ctrl_flags[0]) begin
              r_reg_we <= 1'b1;
              r_wsel   <= 2'd2;
            end else if (w_d_alu) begin
              r_reg_we <= 1'b1;
              r_wsel   <= 2'd0;
            end
          end
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          if (r_halt) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (r_mem) begin
            r_req   <= 1'b1;
            r_we    <= r_mw;
            r_addr  <= w_alu_ext[ADDR_W-1:0];
            r_wdata <= rd_data;
            r_state <= S_MEM;
          end else begin
            if (w_go) begin
              r_pc <= r_jr ? w_rs_ext[ADDR_W-1:0] : w_pc_rel;
            end
            r_state <= S_FETCH_HI;
          end
        end
        S_MEM: begin
          if (w_ack) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            if (r_we) begin
              r_retire <= 1'b1;
              r_state  <= S_FETCH_HI;
            end else begin
              r_load   <= mem_rdata;
              r_reg_we <= 1'b1;
              r_wsel   <= 2'd1;
              r_retire <= 1'b1;
              r_state  <= S_WB;
            end
          end
        end
        S_WB: begin
          r_state <= S_FETCH_HI;
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH_HI;
        end
      endcase
    end
  end

  assign opcode    = r_instr[15:12];
  assign instr     = r_instr;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign reg_we    = r_reg_we;
  assign reg_wsel  = r_wsel;
  assign load_data = r_load;
  assign pc        = r_pc;
  assign retire    = r_retire;
  assign halted    = r_halted;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Multi-cycle instruction fetch/execute sequencer for the 8-bit core; drives the decode ROM and consumes its outputs.
- Fetches 16-bit instructions as two bytes over the shared byte-wide memory handshake and presents `opcode` to the decode ROM.
- Samples the returned control flags and sequences register write-back, data memory access, PC update and halt.
- The ALU datapath and register file sit beside it and exchange operands and results through the ports below.

Parameters:
- ADDR_W, 8, width of PC and memory address; all PC arithmetic wraps mod 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  out  4  instr[15:12], to decode ROM.
- ctrl_flags  in  16  decode ROM control flags for `opcode`.
- instr  out  16  latched instruction: [11:8] rd, [7:4] rs, [7:0] imm8.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  store data.
- mem_rdata  in  8  read data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.
- alu_result  in  8  ALU output (computed address for memory ops).
- rs_data  in  8  register rs value (jump target).
- rd_data  in  8  register rd value (store data).
- branch_taken  in  1  datapath branch condition.
- reg_we  out  1  register write strobe, one cycle.
- reg_wsel  out  2  write source: 0 ALU, 1 load_data, 2 imm8, 3 link PC.
- load_data  out  8  byte captured by a load.
- pc  out  ADDR_W  current PC; doubles as the link value.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  high in HALT.

Behaviour:
- Reset, asynchronous: state FETCH_HI, pc=RESET_PC, instr=0, load_data=0, mem_req=0, mem_we=0, reg_we=0, reg_wsel=0, retire=0, halted=0.
- Reset mid-transaction drops mem_req immediately. A late mem_ack after reset is ignored.
- ctrl_flags bits:
  - 0 ld imm
  - 1 mem read
  - 2 mem write
  - 3 save link
  - 4 pc<-rs_data
  - 5 pc<-pc+sext(imm8)
  - 6 imm operand (no sequencer effect)
  - 7 conditional (gates bits 4/5 with branch_taken)
  - 8 address from alu_result
  - 9 halt
  - 10-15 ignored
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are registered and held stable until the cycle mem_ack=1.
  - mem_req deasserts the cycle after ack.
  - Zero wait states gives a 2-cycle access.
  - mem_ack while mem_req=0 is ignored.
- FETCH_HI: read at pc. On ack: instr[15:8]<=mem_rdata, pc<=pc+1 -> FETCH_LO.
- FETCH_LO: same for instr[7:0], pc+1 -> DECODE. pc now holds the link address.
- DECODE: one cycle for ROM settle. ctrl_flags are registered at the end of this cycle -> EXEC.
- EXEC, priority order:
  - halt -> HALT.
  - mr|mw -> MEM, with mem_addr=alu_result and mem_wdata=rd_data.
  - Otherwise, one cycle: pc update, then write-back, then retire=1 -> FETCH_HI.
- EXEC pc update: if bit4 or bit5 and (!bit7 or branch_taken), pc<=rs_data (bit4 wins) or pc+sext(imm8).
- EXEC write-back:
  - bit3: reg_we=1, wsel=3, value = pre-update pc.
  - bit0: reg_we=1, wsel=2.
  - None of bits 0-5, 9 set: reg_we=1, wsel=0.
  - Otherwise no write.
- MEM, on ack:
  - Read: load_data<=mem_rdata -> WB.
  - Write: retire -> FETCH_HI.
- WB: reg_we=1, wsel=1, retire=1 -> FETCH_HI.
- HALT: no requests, halted=1, exits only by reset.
- reg_we and retire are always single-cycle pulses.
- PC wrap: 0xFF+1 = 0x00 at ADDR_W=8. Relative targets wrap likewise.

Test Plan:
- ldi: bytes [0x00]=0xF3, [0x01]=0x5A, ack 1 cycle after req -> opcode=0xF; EXEC reg_we=1, wsel=2, instr[11:8]=3, imm8=0x5A; pc=0x02; retire once. Next fetch addr=0x02.
- jli at pc 0x10: bytes 0x81, 0xFE -> reg_we with wsel=3 while pc=0x12; next fetch addr=0x10.
- Conditional branch 0x9xFE at 0x10:
  - branch_taken=0 -> pc=0x12, no reg_we.
  - branch_taken=1 -> next fetch 0x10.
- ldb 0xE1xx, alu_result=0x40, mem_ack after 3 wait cycles with rdata 0x77 -> MEM addr 0x40 with mem_we=0 held stable; load_data=0x77; WB reg_we=1, wsel=1.
- stb 0xD2xx, alu_result=0x80, rd_data=0x3C -> mem_we=1, addr 0x80, wdata 0x3C; no reg_we; retire on ack.
- Halt and reset:
  - 0xA000 -> halted=1, mem_req stays 0 for 20 cycles.
  - rst pulse mid-FETCH_LO wait -> mem_req drops same cycle, pc=RESET_PC; fetch restarts at 0x00; stray ack ignored.
